hazard_scoreboard_unit: RTL

- Second-generation pipeline hazard unit for the 5-stage scalar+vector SIMD core.
- Adds a per-register pending-write scoreboard (scalar and vector banks) for variable-latency ops such as the data accelerator.
- Forwarding is independent per operand with M-over-W priority.
- Adds a registered stall-cause FSM and a stall watchdog.
- Sits beside the datapath and drives the stall, flush and forward controls of every pipeline register.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 26 ++
 rtl/hazard_scoreboard_unit_bank.sv | 55 +++++
 rtl/hazard_scoreboard_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and constants for the hazard/scoreboard unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int DEF_R    = 5;
  localparam int DEF_NREG = 32;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOADUSE    = 2'b01,
    SCOREBOARD = 2'b10,
    FREEZE     = 2'b11
  } stall_cause_t;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_unit_bank.sv
// ============================================================================
// Module : hazard_scoreboard_bank
// Brief  : One bank of pending-write bits with set/clear and three lookups.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_bank #(
  parameter int R    = 5,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [R-1:0]    set_addr,
  input  logic            clr_en,
  input  logic [R-1:0]    clr_addr,
  input  logic [R-1:0]    rd1_addr,
  input  logic [R-1:0]    rd2_addr,
  input  logic [R-1:0]    rd3_addr,
  output logic [NREG-1:0] pending,
  output logic            hit1,
  output logic            hit2,
  output logic            hit3
);

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] m1;
  logic [NREG-1:0] m2;
  logic [NREG-1:0] m3;

  // Full decode per register; addresses with no matching slot fall out naturally.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam logic [R-1:0] IDX = R'(i);
    assign set_vec[i] = set_en && (set_addr == IDX);
    assign clr_vec[i] = clr_en && (clr_addr == IDX);
    assign m1[i]      = (rd1_addr == IDX);
    assign m2[i]      = (rd2_addr == IDX);
    assign m3[i]      = (rd3_addr == IDX);
  end

  // Set dominates a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | set_vec;
  end

  assign hit1 = |(pending & m1);
  assign hit2 = |(pending & m2);
  assign hit3 = |(pending & m3);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module : hazard_scoreboard_unit
// Brief  : Pipeline hazard unit: forwarding, load-use, scoreboard, stall FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int R           = DEF_R,
  parameter int NREG        = DEF_NREG,
  parameter int SCALAR_ZERO = 1,
  parameter int STALL_LIMIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    RA1D,
  input  logic [R-1:0]    RA2D,
  input  logic [R-1:0]    WA3D,
  input  logic            Src1VecD,
  input  logic            Src2VecD,
  input  logic            DstVecD,
  input  logic            LongOpD,
  input  logic            RegWriteD,
  input  logic [R-1:0]    RA1E,
  input  logic [R-1:0]    RA2E,
  input  logic [R-1:0]    WA3E,
  input  logic            Src1VecE,
  input  logic            Src2VecE,
  input  logic            DstVecE,
  input  logic            MemtoRegE,
  input  logic            BranchTakenE,
  input  logic            PCSrcE,
  input  logic            PCSrcM,
  input  logic            PCSrcW,
  input  logic            RegWriteM,
  input  logic            RegWriteVM,
  input  logic            RegWriteW,
  input  logic            RegWriteVW,
  input  logic [R-1:0]    WA3M,
  input  logic [R-1:0]    WA3W,
  input  logic            BusyDA,
  input  logic            LongDone,
  input  logic            LongDoneVec,
  input  logic [R-1:0]    LongDoneWA,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            StallW,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [1:0]      ForwardAVE,
  output logic [1:0]      ForwardBVE,
  output logic [1:0]      StallCause,
  output logic [7:0]      StallCycles,
  output logic            StallTimeout,
  output logic [NREG-1:0] PendingS,
  output logic [NREG-1:0] PendingV
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic         ok_m, ok_w;
  logic         lu, sb, redir;
  logic         set_ok, set_s, set_v;
  logic         s1, s2, s3, v1, v2, v3;
  stall_cause_t state, next_state;

  // Scalar r0 is hardwired when SCALAR_ZERO is set, so it never sources a forward.
  assign ok_m = !((SCALAR_ZERO != 0) && (WA3M == '0));
  assign ok_w = !((SCALAR_ZERO != 0) && (WA3W == '0));

  assign ForwardAE  = (RegWriteM && !Src1VecE && WA3M == RA1E && ok_m) ? FWD_M :
                      (RegWriteW && !Src1VecE && WA3W == RA1E && ok_w) ? FWD_W : FWD_RF;
  assign ForwardBE  = (RegWriteM && !Src2VecE && WA3M == RA2E && ok_m) ? FWD_M :
                      (RegWriteW && !Src2VecE && WA3W == RA2E && ok_w) ? FWD_W : FWD_RF;
  assign ForwardAVE = (RegWriteVM && Src1VecE && WA3M == RA1E) ? FWD_M :
                      (RegWriteVW && Src1VecE && WA3W == RA1E) ? FWD_W : FWD_RF;
  assign ForwardBVE = (RegWriteVM && Src2VecE && WA3M == RA2E) ? FWD_M :
                      (RegWriteVW && Src2VecE && WA3W == RA2E) ? FWD_W : FWD_RF;

  assign lu = MemtoRegE && (((RA1D == WA3E) && (Src1VecD == DstVecE)) ||
                            ((RA2D == WA3E) && (Src2VecD == DstVecE)));
  assign sb = (Src1VecD ? v1 : s1) | (Src2VecD ? v2 : s2) |
              (RegWriteD & (DstVecD ? v3 : s3));
  assign redir = BranchTakenE | PCSrcE | PCSrcM | PCSrcW;

  assign StallF = ((lu | sb) & !redir) | BusyDA;
  assign StallD = StallF;
  assign StallE = BusyDA;
  assign StallM = BusyDA;
  assign StallW = BusyDA;
  assign FlushD = redir & !BusyDA;
  assign FlushE = (redir | lu | sb) & !BusyDA;

  assign set_ok = RegWriteD && LongOpD && !StallD && !FlushD;
  assign set_s  = set_ok && !DstVecD && !((SCALAR_ZERO != 0) && (WA3D == '0));
  assign set_v  = set_ok && DstVecD;

  hazard_scoreboard_bank #(.R(R), .NREG(NREG)) u_bank_s (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_s),
    .set_addr (WA3D),
    .clr_en   (LongDone && !LongDoneVec),
    .clr_addr (LongDoneWA),
    .rd1_addr (RA1D),
    .rd2_addr (RA2D),
    .rd3_addr (WA3D),
    .pending  (PendingS),
    .hit1     (s1),
    .hit2     (s2),
    .hit3     (s3)
  );

  hazard_scoreboard_bank #(.R(R), .NREG(NREG)) u_bank_v (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_v),
    .set_addr (WA3D),
    .clr_en   (LongDone && LongDoneVec),
    .clr_addr (LongDoneWA),
    .rd1_addr (RA1D),
    .rd2_addr (RA2D),
    .rd3_addr (WA3D),
    .pending  (PendingV),
    .hit1     (v1),
    .hit2     (v2),
    .hit3     (v3)
  );

  always_comb begin
    next_state = RUN;
    if (BusyDA)           next_state = FREEZE;
    else if (lu && !redir) next_state = LOADUSE;
    else if (sb && !redir) next_state = SCOREBOARD;
  end

  // Counter and watchdog look at the cause being entered, not the one held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      StallCycles  <= 8'd0;
      StallTimeout <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != RUN) begin
        if (StallCycles != 8'hFF) StallCycles <= StallCycles + 8'd1;
        if (StallCycles == LIMIT) StallTimeout <= 1'b1;
      end else begin
        StallCycles <= 8'd0;
      end
    end
  end

  assign StallCause = state;

endmodule

`default_nettype wire
